// File: rtl/rvic_axil_aligner_pkg.sv
`default_nettype none
// ============================================================================
// Module : rvic_axil_aligner_pkg
// Brief  : Shared states, response codes and legality helper for the aligner
// Rev    : 1.0
// ============================================================================
package rvic_axil_aligner_pkg;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        WR_ISSUE = 4'd1,
        RD_ISSUE = 4'd2,
        WR_RESP  = 4'd3,
        RD_RESP  = 4'd4,
        W_ERR    = 4'd5,
        R_ERR    = 4'd6,
        B_HOLD   = 4'd7,
        R_HOLD   = 4'd8
    } state_e;

    typedef enum logic {
        RR_WRITE = 1'b0,
        RR_READ  = 1'b1
    } rr_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Only the low address bits matter: the widest legal access is 8 bytes.
    function automatic logic size_legal(input logic [2:0] addr_lo, input logic [2:0] size);
        logic ok;
        case (size)
            3'd0:    ok = 1'b1;
            3'd1:    ok = (addr_lo[0] == 1'b0);
            3'd2:    ok = (addr_lo[1:0] == 2'b00);
            3'd3:    ok = (addr_lo == 3'b000);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rvic_axil_aligner_if.sv
`default_nettype none
// ============================================================================
// Module : rvic_axil_if
// Brief  : AXI-lite bundle (with size side-band) plus slave/master views
// Rev    : 1.0
// ============================================================================
interface rvic_axil_if #(
    parameter int AddrWidth = 64,
    parameter int DataWidth = 64
);
    logic [AddrWidth-1:0]   awaddr;
    logic [2:0]             awsize;
    logic                   awvalid;
    logic                   awready;
    logic [DataWidth-1:0]   wdata;
    logic [DataWidth/8-1:0] wstrb;
    logic                   wvalid;
    logic                   wready;
    logic [AddrWidth-1:0]   araddr;
    logic [2:0]             arsize;
    logic                   arvalid;
    logic                   arready;
    logic [DataWidth-1:0]   rdata;
    logic [1:0]             rresp;
    logic                   rvalid;
    logic                   rready;
    logic [1:0]             bresp;
    logic                   bvalid;
    logic                   bready;

    modport slave (
        input  awaddr, awsize, awvalid, wdata, wstrb, wvalid,
        input  araddr, arsize, arvalid, rready, bready,
        output awready, wready, arready, rdata, rresp, rvalid, bresp, bvalid
    );

    modport master (
        output awaddr, awsize, awvalid, wdata, wstrb, wvalid,
        output araddr, arsize, arvalid, rready, bready,
        input  awready, wready, arready, rdata, rresp, rvalid, bresp, bvalid
    );
endinterface
`default_nettype wire

// File: rtl/rvic_axil_aligner_slot.sv
`default_nettype none
// ============================================================================
// Module : rvic_axil_slot
// Brief  : One-entry valid/ready register slice; ready held low through reset
// Rev    : 1.0
// ============================================================================
module rvic_axil_slot #(
    parameter type T = logic
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
    output logic in_ready,
    input  T     in_data,
    output logic full,
    output T     data,
    input  logic pop
);
    logic full_q, full_d;
    logic en_q, en_d;
    T     data_q, data_d;

    always_comb begin
        full_d = full_q;
        data_d = data_q;
        en_d   = 1'b1;
        if (pop) begin
            full_d = 1'b0;
        end
        if (in_valid && in_ready) begin
            full_d = 1'b1;
            data_d = in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            data_q <= '0;
            en_q   <= 1'b0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
            en_q   <= en_d;
        end
    end

    assign in_ready = en_q && !full_q;
    assign full     = full_q;
    assign data     = data_q;

endmodule
`default_nettype wire

// File: rtl/rvic_axil_aligner.sv
`default_nettype none
// ============================================================================
// Module : rvic_axil_aligner
// Brief  : Buffers AW/W/AR, issues AW+W jointly, one transaction in flight
// Rev    : 1.0
// ============================================================================
module rvic_axil_aligner
    import rvic_axil_aligner_pkg::*;
#(
    parameter int AddrWidth = 64,
    parameter int DataWidth = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    rvic_axil_if.slave        s_axi,
    rvic_axil_if.master       m_axi,
    output logic [2:0]        w_reqbuf_size,
    output logic [2:0]        r_reqbuf_size
);
    typedef struct packed {
        logic [AddrWidth-1:0] addr;
        logic [2:0]           size;
    } addr_req_t;

    typedef struct packed {
        logic [DataWidth-1:0]   data;
        logic [DataWidth/8-1:0] strb;
    } wdat_t;

    addr_req_t aw_in, aw_req, ar_in, ar_req;
    wdat_t     w_in, w_req;
    logic      aw_full, w_full, ar_full;
    logic      aw_pop, w_pop, ar_pop;

    assign aw_in = '{addr: s_axi.awaddr, size: s_axi.awsize};
    assign ar_in = '{addr: s_axi.araddr, size: s_axi.arsize};
    assign w_in  = '{data: s_axi.wdata, strb: s_axi.wstrb};

    rvic_axil_slot #(.T(addr_req_t)) u_aw_slot (
        .clk(clk), .rst_n(rst_n),
        .in_valid(s_axi.awvalid), .in_ready(s_axi.awready), .in_data(aw_in),
        .full(aw_full), .data(aw_req), .pop(aw_pop)
    );

    rvic_axil_slot #(.T(wdat_t)) u_w_slot (
        .clk(clk), .rst_n(rst_n),
        .in_valid(s_axi.wvalid), .in_ready(s_axi.wready), .in_data(w_in),
        .full(w_full), .data(w_req), .pop(w_pop)
    );

    rvic_axil_slot #(.T(addr_req_t)) u_ar_slot (
        .clk(clk), .rst_n(rst_n),
        .in_valid(s_axi.arvalid), .in_ready(s_axi.arready), .in_data(ar_in),
        .full(ar_full), .data(ar_req), .pop(ar_pop)
    );

    state_e               state_q, state_d;
    rr_e                  rr_last_q, rr_last_d;
    logic [2:0]           w_size_q, w_size_d;
    logic [2:0]           r_size_q, r_size_d;
    logic [1:0]           resp_q, resp_d;
    logic [DataWidth-1:0] rdata_q, rdata_d;
    logic                 wr_cand, rd_cand, grant_wr, grant_rd;

    always_comb begin
        state_d   = state_q;
        rr_last_d = rr_last_q;
        w_size_d  = w_size_q;
        r_size_d  = r_size_q;
        resp_d    = resp_q;
        rdata_d   = rdata_q;
        aw_pop    = 1'b0;
        w_pop     = 1'b0;
        ar_pop    = 1'b0;
        wr_cand   = aw_full && w_full;
        rd_cand   = ar_full;
        grant_wr  = wr_cand && (!rd_cand || (rr_last_q == RR_READ));
        grant_rd  = rd_cand && !grant_wr;

        case (state_q)
            IDLE: begin
                // Round-robin pointer only moves when both sides contend.
                if (grant_wr) begin
                    if (rd_cand) rr_last_d = RR_WRITE;
                    if (size_legal(aw_req.addr[2:0], aw_req.size)) begin
                        state_d  = WR_ISSUE;
                        w_size_d = aw_req.size;
                    end else begin
                        state_d = W_ERR;
                    end
                end else if (grant_rd) begin
                    if (wr_cand) rr_last_d = RR_READ;
                    if (size_legal(ar_req.addr[2:0], ar_req.size)) begin
                        state_d  = RD_ISSUE;
                        r_size_d = ar_req.size;
                    end else begin
                        state_d = R_ERR;
                    end
                end
            end
            WR_ISSUE: begin
                if (m_axi.awready && m_axi.wready) begin
                    aw_pop  = 1'b1;
                    w_pop   = 1'b1;
                    state_d = WR_RESP;
                end
            end
            RD_ISSUE: begin
                if (m_axi.arready) begin
                    ar_pop  = 1'b1;
                    state_d = RD_RESP;
                end
            end
            WR_RESP: begin
                if (m_axi.bvalid) begin
                    resp_d  = m_axi.bresp;
                    state_d = B_HOLD;
                end
            end
            RD_RESP: begin
                if (m_axi.rvalid) begin
                    resp_d  = m_axi.rresp;
                    rdata_d = m_axi.rdata;
                    state_d = R_HOLD;
                end
            end
            W_ERR: begin
                aw_pop  = 1'b1;
                w_pop   = 1'b1;
                resp_d  = RESP_SLVERR;
                state_d = B_HOLD;
            end
            R_ERR: begin
                ar_pop  = 1'b1;
                resp_d  = RESP_SLVERR;
                rdata_d = '0;
                state_d = R_HOLD;
            end
            B_HOLD: begin
                if (s_axi.bready) state_d = IDLE;
            end
            R_HOLD: begin
                if (s_axi.rready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rr_last_q <= RR_READ;
            w_size_q  <= 3'd0;
            r_size_q  <= 3'd0;
            resp_q    <= RESP_OKAY;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            rr_last_q <= rr_last_d;
            w_size_q  <= w_size_d;
            r_size_q  <= r_size_d;
            resp_q    <= resp_d;
            rdata_q   <= rdata_d;
        end
    end

    logic wr_issue, rd_issue, b_hold, r_hold;
    assign wr_issue = (state_q == WR_ISSUE);
    assign rd_issue = (state_q == RD_ISSUE);
    assign b_hold   = (state_q == B_HOLD);
    assign r_hold   = (state_q == R_HOLD);

    assign m_axi.awvalid = wr_issue;
    assign m_axi.awaddr  = wr_issue ? aw_req.addr : '0;
    assign m_axi.awsize  = wr_issue ? w_size_q : 3'd0;
    assign m_axi.wvalid  = wr_issue;
    assign m_axi.wdata   = wr_issue ? w_req.data : '0;
    assign m_axi.wstrb   = wr_issue ? w_req.strb : '0;
    assign m_axi.arvalid = rd_issue;
    assign m_axi.araddr  = rd_issue ? ar_req.addr : '0;
    assign m_axi.arsize  = rd_issue ? r_size_q : 3'd0;
    assign m_axi.bready  = (state_q == WR_RESP);
    assign m_axi.rready  = (state_q == RD_RESP);

    assign s_axi.bvalid  = b_hold;
    assign s_axi.bresp   = b_hold ? resp_q : RESP_OKAY;
    assign s_axi.rvalid  = r_hold;
    assign s_axi.rresp   = r_hold ? resp_q : RESP_OKAY;
    assign s_axi.rdata   = r_hold ? rdata_q : '0;

    // Registered sizes stay put after the slot frees, through the response.
    assign w_reqbuf_size = w_size_q;
    assign r_reqbuf_size = r_size_q;

endmodule
`default_nettype wire
